// File: rtl/serial_shift_unit_if.sv
// Request/result bundle between the register-file read side, the shift unit
// and the register-file write port.
interface serial_shift_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic            wEn;
   logic [4:0]      rd;
   logic [XLEN-1:0] data;

   modport master (
      output start, op, rs1_val, rs2_val, rd_in,
      input  busy, done, wEn, rd, data
   );

   modport slave (
      input  start, op, rs1_val, rs2_val, rd_in,
      output busy, done, wEn, rd, data
   );
endinterface

// File: rtl/serial_shift_unit.sv
// RV32I shift execute unit: shifts one bit per cycle and writes the result
// back to the register file in a single DONE cycle.
module serial_shift_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   serial_shift_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [XLEN-1:0]    r_shift;
   logic [XLEN-1:0]    w_shiftNext;
   logic [SHAMT_W-1:0] r_count;
   logic [SHAMT_W-1:0] w_countNext;
   logic [1:0]         r_op;
   logic [1:0]         w_opNext;
   logic [4:0]         r_rd;
   logic [4:0]         w_rdNext;
   logic               w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_count <= '0;
         r_op    <= '0;
         r_rd    <= '0;
      end else begin
         r_state <= w_nextState;
         r_shift <= w_shiftNext;
         r_count <= w_countNext;
         r_op    <= w_opNext;
         r_rd    <= w_rdNext;
      end
   end

   // op encoding is {arith,right}; 2'b10 has no meaning and falls into SLL
   always_comb begin
      w_nextState = r_state;
      w_shiftNext = r_shift;
      w_countNext = r_count;
      w_opNext    = r_op;
      w_rdNext    = r_rd;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_shiftNext = bus.rs1_val;
               w_countNext = bus.rs2_val[SHAMT_W-1:0];
               w_opNext    = bus.op;
               w_rdNext    = bus.rd_in;
               w_nextState = (bus.rs2_val[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            case (r_op)
               2'b01:   w_shiftNext = {1'b0, r_shift[XLEN-1:1]};
               2'b11:   w_shiftNext = {r_shift[XLEN-1], r_shift[XLEN-1:1]};
               default: w_shiftNext = {r_shift[XLEN-2:0], 1'b0};
            endcase
            w_countNext = r_count - SHAMT_W'(1);
            if (r_count == SHAMT_W'(1)) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // data/rd hold their last result in IDLE; only done and wEn qualify them
   assign w_done   = (r_state == DONE);
   assign bus.done = w_done;
   assign bus.busy = (r_state != IDLE);
   assign bus.wEn  = w_done && (r_rd != 5'd0);
   assign bus.rd   = r_rd;
   assign bus.data = r_shift;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: directed scenarios plus random
// operations compared against a plain-arithmetic shift model.
module tb_serial_shift_unit;

   logic clk;
   logic reset;
   int   testCount;
   int   failCount;

   serial_shift_unit_if #(.XLEN(32)) ifc ();

   serial_shift_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int n);
      case (op)
         2'b01:   return a >> n;
         2'b11:   return 32'($signed(a) >>> n);
         default: return a << n;
      endcase
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one request in cycle 0 and follows it to its DONE cycle; with
   // disturb set, inputs churn and start re-pulses while the unit is busy.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rdIdx, input bit disturb);
      logic [31:0] expData;
      int          n;
      int          lat;
      bit          busyOk;
      n       = int'(b[4:0]);
      expData = model(op, a, n);
      ifc.op      = op;
      ifc.rs1_val = a;
      ifc.rs2_val = b;
      ifc.rd_in   = rdIdx;
      ifc.start   = 1'b1;
      stepCycle();
      lat       = 1;
      ifc.start = 1'b0;
      busyOk    = 1'b1;
      while (ifc.done !== 1'b1 && lat < 40) begin
         if (ifc.busy !== 1'b1) busyOk = 1'b0;
         if (disturb) begin
            ifc.rs1_val = $urandom;
            ifc.rs2_val = $urandom;
            ifc.rd_in   = 5'($urandom);
            ifc.op      = 2'($urandom);
            ifc.start   = (lat == 3) || ($urandom_range(0, 3) == 0);
         end
         stepCycle();
         lat++;
      end
      ifc.start = 1'b0;
      checkOutput("latency", 32'(lat), 32'(n + 1));
      checkOutput("busyWhileShifting", 32'(busyOk), 32'd1);
      checkOutput("busyInDone", 32'(ifc.busy), 32'd1);
      checkOutput("data", ifc.data, expData);
      checkOutput("rd", 32'(ifc.rd), 32'(rdIdx));
      checkOutput("wEn", 32'(ifc.wEn), 32'(rdIdx != 5'd0));
      stepCycle();
      checkOutput("doneAfter", 32'(ifc.done), 32'd0);
      checkOutput("busyAfter", 32'(ifc.busy), 32'd0);
      checkOutput("wEnAfter", 32'(ifc.wEn), 32'd0);
      checkOutput("dataHold", ifc.data, expData);
      checkOutput("rdHold", 32'(ifc.rd), 32'(rdIdx));
   endtask

   initial begin
      int  sawDone;
      testCount   = 0;
      failCount   = 0;
      reset       = 1'b1;
      ifc.start   = 1'b0;
      ifc.op      = 2'b00;
      ifc.rs1_val = '0;
      ifc.rs2_val = '0;
      ifc.rd_in   = '0;
      stepCycle();
      stepCycle();
      checkOutput("rstBusy", 32'(ifc.busy), 32'd0);
      checkOutput("rstDone", 32'(ifc.done), 32'd0);
      checkOutput("rstWEn", 32'(ifc.wEn), 32'd0);
      checkOutput("rstRd", 32'(ifc.rd), 32'd0);
      checkOutput("rstData", ifc.data, 32'd0);
      reset = 1'b0;

      applyStimulus(2'b00, 32'd1, 32'd4, 5'd2, 1'b0);
      checkOutput("sll1by4", ifc.data, 32'd16);
      applyStimulus(2'b11, 32'h8000_0000, 32'd31, 5'd3, 1'b0);
      checkOutput("sra31", ifc.data, 32'hFFFF_FFFF);
      applyStimulus(2'b01, 32'h8000_0000, 32'd31, 5'd3, 1'b0);
      checkOutput("srl31", ifc.data, 32'h0000_0001);
      applyStimulus(2'b01, 32'hF0F0_F0F0, 32'h0000_0025, 5'd4, 1'b0);
      checkOutput("srlUpperIgnored", ifc.data, 32'h0787_8787);
      applyStimulus(2'b01, 32'hF0F0_F0F0, 32'd0, 5'd5, 1'b0);
      checkOutput("shiftZero", ifc.data, 32'hF0F0_F0F0);
      applyStimulus(2'b00, 32'd7, 32'd2, 5'd0, 1'b0);
      checkOutput("x0Data", ifc.data, 32'd28);
      applyStimulus(2'b10, 32'h0000_00F1, 32'd3, 5'd9, 1'b0);
      checkOutput("op10AsSll", ifc.data, 32'h0000_0788);

      applyStimulus(2'b00, 32'd1, 32'd8, 5'd6, 1'b1);
      checkOutput("ignoreStart", ifc.data, 32'd256);
      sawDone = 0;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         if (ifc.done === 1'b1) sawDone++;
      end
      checkOutput("singleDone", 32'(sawDone), 32'd0);

      // abort a long SRA with reset in cycle 10
      ifc.op      = 2'b11;
      ifc.rs1_val = 32'h8123_4567;
      ifc.rs2_val = 32'd20;
      ifc.rd_in   = 5'd7;
      ifc.start   = 1'b1;
      stepCycle();
      ifc.start = 1'b0;
      for (int i = 1; i < 10; i++) stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("abortBusy", 32'(ifc.busy), 32'd0);
      checkOutput("abortDone", 32'(ifc.done), 32'd0);
      checkOutput("abortWEn", 32'(ifc.wEn), 32'd0);
      checkOutput("abortData", ifc.data, 32'd0);
      sawDone = 0;
      for (int i = 0; i < 25; i++) begin
         stepCycle();
         if (ifc.done === 1'b1 || ifc.busy === 1'b1) sawDone++;
      end
      checkOutput("abortQuiet", 32'(sawDone), 32'd0);
      applyStimulus(2'b11, 32'h8123_4567, 32'd20, 5'd7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
